// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension unit (MUL*/DIV*/REM*, RV64 W-forms).
// One operation is accepted at a time; finished results go to a small result queue.
// Handshakes: a transfer happens on a rising edge where both valid and ready are
// high; ready never depends on valid, and a valid source holds its payload until taken.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int RQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs0_word,
    input  logic [XLEN-1:0] rs1_word,
    input  logic            flush,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW = $clog2(RQ_DEPTH + 1);
    localparam int DW = 2 * XLEN;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = {XLEN{v[31]}};
        r[31:0] = v[31:0];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        r[31:0] = v[31:0];
        return r;
    endfunction

    logic [1:0]      state;
    logic [6:0]      cnt;
    logic [DW-1:0]   acc, mcand;
    logic [XLEN-1:0] mplier, rem, quo, dvsr;
    logic [4:0]      r_rd;
    logic [2:0]      r_f3;
    logic            r_w, r_neg_a, r_neg_b;

    logic [XLEN-1:0] q_data [RQ_DEPTH];
    logic [4:0]      q_rd   [RQ_DEPTH];
    logic [PW-1:0]   rptr, wptr;
    logic [CW-1:0]   qcnt;

    logic [4:0]      opc;
    logic [2:0]      f3;
    logic            is_w, is_m, a_signed, b_signed, a_neg, b_neg;
    logic            direct, accept, enq, deq;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_w, ones, direct_val, enq_data;
    logic [6:0]      iters;
    logic [DW-1:0]   mul_next, prod;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] fix_val;
    logic            unused_bits;

    assign unused_bits = ^{instr[31:26], instr[24:15]};
    assign ones        = '1;

    assign in_rdy = rst & ~flush & (state == S_IDLE) & (qcnt < CW'(RQ_DEPTH));
    assign accept = in_vld & in_rdy;
    assign out_vld = (qcnt != '0);
    assign deq     = out_vld & out_rdy;
    assign out_data = out_vld ? q_data[rptr] : '0;
    assign out_rd   = out_vld ? q_rd[rptr] : 5'd0;
    assign busy     = (state != S_IDLE) | (qcnt != '0);

    // Decode, operand extension/magnitude, and the results computed without iterating.
    always_comb begin
        opc      = instr[6:2];
        f3       = instr[14:12];
        is_w     = (opc == 5'b01110) && (XLEN == 64);
        is_m     = (instr[1:0] == 2'b11) && instr[25] && ((opc == 5'b01100) || is_w);
        a_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
        b_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
        a_ext    = is_w ? (a_signed ? sext32(rs0_word) : zext32(rs0_word)) : rs0_word;
        b_ext    = is_w ? (b_signed ? sext32(rs1_word) : zext32(rs1_word)) : rs1_word;
        a_neg    = a_signed & a_ext[XLEN-1];
        b_neg    = b_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_w    = is_w ? (ones << 31) : (ones << (XLEN - 1));
        iters    = f3[2] ? (is_w ? 7'd32 : 7'(XLEN))
                         : (is_w ? 7'(32 / MUL_STEP) : 7'(XLEN / MUL_STEP));
        direct     = 1'b0;
        direct_val = '0;
        if (!f3[2]) begin
            direct = (a_ext == '0) || (b_ext == '0);
        end else if (b_ext == '0) begin
            direct     = 1'b1;
            direct_val = f3[1] ? a_ext : ones;
        end else if (!f3[0] && (a_ext == min_w) && (b_ext == ones)) begin
            direct     = 1'b1;
            direct_val = f3[1] ? '0 : a_ext;
        end
        if (is_w) direct_val = sext32(direct_val);
    end

    // One multiplier step (MUL_STEP partial products) and one restoring divide step.
    always_comb begin
        mul_next = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) mul_next = mul_next + (mcand << i);
        end
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {1'b0, dvsr};
    end

    // Sign fix-up and result-half selection for the iterated result.
    always_comb begin
        prod = (r_neg_a ^ r_neg_b) ? -acc : acc;
        if (r_f3[2]) begin
            if (r_f3[1]) fix_val = r_neg_a ? -rem : rem;
            else         fix_val = (r_neg_a ^ r_neg_b) ? -quo : quo;
        end else if (r_w) begin
            fix_val = (r_f3[1:0] != 2'b00) ? XLEN'(prod[63:32]) : XLEN'(prod[31:0]);
        end else begin
            fix_val = (r_f3[1:0] != 2'b00) ? prod[DW-1:XLEN] : prod[XLEN-1:0];
        end
        if (r_w) fix_val = sext32(fix_val);
        enq      = ~flush & ((accept & is_m & direct) | (state == S_FIX));
        enq_data = (state == S_FIX) ? fix_val : direct_val;
    end

    // Control FSM and iteration datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            r_rd    <= '0;
            r_f3    <= '0;
            r_w     <= 1'b0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_m && !direct) begin
                        state   <= f3[2] ? S_DIV : S_MUL;
                        cnt     <= iters;
                        acc     <= '0;
                        mcand   <= {{XLEN{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        rem     <= '0;
                        // W-form dividend sits in the top half so its MSB shifts out first.
                        quo     <= is_w ? (a_mag << 32) : a_mag;
                        dvsr    <= b_mag;
                        r_rd    <= instr[11:7];
                        r_f3    <= f3;
                        r_w     <= is_w;
                        r_neg_a <= a_neg;
                        r_neg_b <= b_neg;
                    end
                end
                S_MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt - 7'd1;
                    if (cnt == 7'd1) state <= S_FIX;
                end
                S_DIV: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) state <= S_FIX;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result queue: circular FIFO, enqueue and dequeue may coincide at any fill level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr <= '0;
            wptr <= '0;
            qcnt <= '0;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                q_data[i] <= '0;
                q_rd[i]   <= '0;
            end
        end else if (flush) begin
            rptr <= '0;
            wptr <= '0;
            qcnt <= '0;
        end else begin
            if (enq) begin
                q_data[wptr] <= enq_data;
                q_rd[wptr]   <= (state == S_FIX) ? r_rd : instr[11:7];
                wptr <= (wptr == PW'(RQ_DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (deq) rptr <= (rptr == PW'(RQ_DEPTH - 1)) ? '0 : rptr + 1'b1;
            if (enq && !deq)      qcnt <= qcnt + 1'b1;
            else if (!enq && deq) qcnt <= qcnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for a 32-bit and a 64-bit muldiv_unit instance,
// plus hand sequences for backpressure, flush and mid-operation reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, flush, in_vld_drv, out_rdy, sel64;
    logic [31:0] instr;
    logic [63:0] rs0, rs1;

    logic        in_rdy32, out_vld32, busy32, in_rdy64, out_vld64, busy64;
    logic [4:0]  out_rd32, out_rd64;
    logic [31:0] out_data32;
    logic [63:0] out_data64;
    logic        c_rdy, c_vld, c_busy;
    logic [4:0]  c_rd;
    logic [63:0] c_data;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        is64;
        logic        w;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    // clock / reset
    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_STEP(2), .RQ_DEPTH(2)) u_d32 (
        .clk(clk), .rst(rst), .in_vld(in_vld_drv & ~sel64), .in_rdy(in_rdy32),
        .instr(instr), .rs0_word(rs0[31:0]), .rs1_word(rs1[31:0]), .flush(flush),
        .out_vld(out_vld32), .out_rdy(out_rdy), .out_rd(out_rd32),
        .out_data(out_data32), .busy(busy32)
    );

    muldiv_unit #(.XLEN(64), .MUL_STEP(2), .RQ_DEPTH(2)) u_d64 (
        .clk(clk), .rst(rst), .in_vld(in_vld_drv & sel64), .in_rdy(in_rdy64),
        .instr(instr), .rs0_word(rs0), .rs1_word(rs1), .flush(flush),
        .out_vld(out_vld64), .out_rdy(out_rdy), .out_rd(out_rd64),
        .out_data(out_data64), .busy(busy64)
    );

    assign c_rdy  = sel64 ? in_rdy64  : in_rdy32;
    assign c_vld  = sel64 ? out_vld64 : out_vld32;
    assign c_busy = sel64 ? busy64    : busy32;
    assign c_rd   = sel64 ? out_rd64  : out_rd32;
    assign c_data = sel64 ? out_data64 : {32'd0, out_data32};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard compare
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic w);
        mk = {7'b0000001, 10'd0, f3, rd, (w ? 7'b0111011 : 7'b0110011)};
    endfunction

    function automatic vec_t mkv(input logic is64, input logic w, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] exp, input int lat);
        vec_t v;
        v.is64 = is64; v.w = w; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    // driver: wait for in_rdy (bounded), present one op for one accepting edge
    task automatic accept_op(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (!c_rdy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("accept_rdy", {63'd0, c_rdy}, 64'd1);
        instr = ins; rs0 = a; rs1 = b; in_vld_drv = 1'b1;
        @(posedge clk);
        #1 in_vld_drv = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        logic [4:0] rd;
        rd = 5'((idx % 31) + 1);
        sel64 = v.is64;
        out_rdy = 1'b1;
        accept_op(mk(v.f3, rd, v.w), v.a, v.b);
        lat = 1;
        while (!c_vld && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check($sformatf("vec%0d_data", idx), c_data, v.exp);
        check($sformatf("vec%0d_rd", idx), {59'd0, c_rd}, {59'd0, rd});
        check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(v.lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  seen;
        vec_t v0;
        rst = 1'b0; flush = 1'b0; in_vld_drv = 1'b0; out_rdy = 1'b1; sel64 = 1'b0;
        instr = '0; rs0 = '0; rs1 = '0;

        vt.push_back(mkv(0, 0, 3'd0, 64'h7,          64'hFFFFFFFD, 64'hFFFFFFEB, 18));
        vt.push_back(mkv(0, 0, 3'd3, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFE, 18));
        vt.push_back(mkv(0, 0, 3'd1, 64'hFFFFFFFE,   64'h3,        64'hFFFFFFFF, 18));
        vt.push_back(mkv(0, 0, 3'd2, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFF, 18));
        vt.push_back(mkv(0, 0, 3'd1, 64'h80000000,   64'h80000000, 64'h40000000, 18));
        vt.push_back(mkv(0, 0, 3'd0, 64'h12345678,   64'h10,       64'h23456780, 18));
        vt.push_back(mkv(0, 0, 3'd3, 64'h12345678,   64'h10,       64'h1,        18));
        vt.push_back(mkv(0, 0, 3'd4, 64'hFFFFFFF9,   64'h2,        64'hFFFFFFFD, 34));
        vt.push_back(mkv(0, 0, 3'd6, 64'hFFFFFFF9,   64'h2,        64'hFFFFFFFF, 34));
        vt.push_back(mkv(0, 0, 3'd5, 64'd100,        64'd7,        64'd14,       34));
        vt.push_back(mkv(0, 0, 3'd7, 64'd100,        64'd7,        64'd2,        34));
        vt.push_back(mkv(0, 0, 3'd4, 64'h7,          64'hFFFFFFFE, 64'hFFFFFFFD, 34));
        vt.push_back(mkv(0, 0, 3'd6, 64'h7,          64'hFFFFFFFE, 64'h1,        34));
        vt.push_back(mkv(0, 0, 3'd4, 64'h80000000,   64'h1,        64'h80000000, 34));
        vt.push_back(mkv(0, 0, 3'd5, 64'h80000000,   64'hFFFFFFFF, 64'h0,        34));
        vt.push_back(mkv(0, 0, 3'd4, 64'h5,          64'h0,        64'hFFFFFFFF, 1));
        vt.push_back(mkv(0, 0, 3'd6, 64'h5,          64'h0,        64'h5,        1));
        vt.push_back(mkv(0, 0, 3'd4, 64'h80000000,   64'hFFFFFFFF, 64'h80000000, 1));
        vt.push_back(mkv(0, 0, 3'd6, 64'h80000000,   64'hFFFFFFFF, 64'h0,        1));
        vt.push_back(mkv(0, 0, 3'd0, 64'h12345,      64'h0,        64'h0,        1));
        vt.push_back(mkv(0, 0, 3'd3, 64'h0,          64'h9,        64'h0,        1));
        vt.push_back(mkv(0, 0, 3'd7, 64'hFFFFFFFF,   64'h0,        64'hFFFFFFFF, 1));
        vt.push_back(mkv(1, 1, 3'd0, 64'h7FFFFFFF,   64'h2,        64'hFFFFFFFFFFFFFFFE, 18));
        vt.push_back(mkv(1, 1, 3'd4, 64'h1_0000000A, 64'h5,        64'h2,                34));
        vt.push_back(mkv(1, 1, 3'd6, 64'hDEADBEEF_FFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFF, 34));
        vt.push_back(mkv(1, 1, 3'd4, 64'h12345678_80000000, 64'hFFFFFFFF, 64'hFFFFFFFF80000000, 1));
        vt.push_back(mkv(1, 1, 3'd5, 64'hFFFFFFFF_00000064, 64'd7, 64'd14,               34));
        vt.push_back(mkv(1, 0, 3'd0, 64'h1_00000000, 64'h3,        64'h3_00000000,       34));
        vt.push_back(mkv(1, 0, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'h2,  64'h1,                34));
        vt.push_back(mkv(1, 0, 3'd4, 64'hFFFFFFFFFFFFFF9C, 64'd7,  64'hFFFFFFFFFFFFFFF2, 66));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_rdy",   {63'd0, in_rdy32},  64'd0);
        check("reset_out_vld",  {63'd0, out_vld32}, 64'd0);
        check("reset_busy",     {63'd0, busy32},    64'd0);
        check("reset_out_data", {32'd0, out_data32}, 64'd0);
        check("reset_out_rd",   {59'd0, out_rd32},  64'd0);
        check("reset_in_rdy64", {63'd0, in_rdy64},  64'd0);
        @(negedge clk) rst = 1'b1;
        #1 check("post_reset_in_rdy", {63'd0, in_rdy32}, 64'd1);

        // vector table
        foreach (vt[i]) run_vec(vt[i], i);
        sel64 = 1'b0;
        check("idle_after_table", {63'd0, busy32 | busy64}, 64'd0);

        // non-M instructions are accepted and dropped
        @(negedge clk);
        instr = mk(3'd0, 5'd7, 1'b0); instr[25] = 1'b0; rs0 = 64'd3; rs1 = 64'd4;
        in_vld_drv = 1'b1;
        @(posedge clk);
        #1 in_vld_drv = 1'b0;
        check("nop_out_vld", {63'd0, c_vld}, 64'd0);
        check("nop_busy", {63'd0, c_busy}, 64'd0);
        accept_op(mk(3'd0, 5'd8, 1'b1), 64'd3, 64'd4);
        check("w_on_rv32_out_vld", {63'd0, c_vld}, 64'd0);
        check("w_on_rv32_busy", {63'd0, c_busy}, 64'd0);

        // backpressure with a two-entry queue
        out_rdy = 1'b0;
        @(negedge clk);
        check("bp_rdy1", {63'd0, c_rdy}, 64'd1);
        instr = mk(3'd4, 5'd1, 1'b0); rs0 = 64'd5; rs1 = 64'd0; in_vld_drv = 1'b1;
        @(negedge clk);
        check("bp_rdy2", {63'd0, c_rdy}, 64'd1);
        instr = mk(3'd6, 5'd2, 1'b0);
        @(negedge clk);
        check("bp_vld", {63'd0, c_vld}, 64'd1);
        check("bp_full_rdy", {63'd0, c_rdy}, 64'd0);
        instr = mk(3'd0, 5'd3, 1'b0); rs0 = 64'd3; rs1 = 64'd0;
        @(negedge clk);
        check("bp_hold_rdy", {63'd0, c_rdy}, 64'd0);
        check("bp_hold_rd", {59'd0, c_rd}, 64'd1);
        check("bp_hold_data", c_data, 64'hFFFFFFFF);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drain1_rd", {59'd0, c_rd}, 64'd2);
        check("bp_drain1_data", c_data, 64'd5);
        check("bp_drain1_rdy", {63'd0, c_rdy}, 64'd1);
        @(posedge clk);
        #1 in_vld_drv = 1'b0;
        check("bp_third_vld", {63'd0, c_vld}, 64'd1);
        check("bp_third_rd", {59'd0, c_rd}, 64'd3);
        check("bp_third_data", c_data, 64'd0);
        @(posedge clk);
        #1;
        check("bp_empty_vld", {63'd0, c_vld}, 64'd0);
        check("bp_empty_busy", {63'd0, c_busy}, 64'd0);

        // flush in DIV cycle 10 with one queued entry
        out_rdy = 1'b0;
        accept_op(mk(3'd4, 5'd4, 1'b0), 64'd5, 64'd0);
        accept_op(mk(3'd5, 5'd5, 1'b0), 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        #1;
        check("fl_pre_vld", {63'd0, c_vld}, 64'd1);
        check("fl_pre_busy", {63'd0, c_busy}, 64'd1);
        @(negedge clk) flush = 1'b1;
        #1 check("fl_in_rdy", {63'd0, c_rdy}, 64'd0);
        @(posedge clk);
        #1;
        check("fl_out_vld", {63'd0, c_vld}, 64'd0);
        check("fl_busy", {63'd0, c_busy}, 64'd0);
        @(negedge clk) flush = 1'b0;
        #1 check("fl_rdy_after", {63'd0, c_rdy}, 64'd1);
        out_rdy = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1 if (c_vld) seen++;
        end
        check("fl_no_result", 64'(seen), 64'd0);

        // reset during MUL with one queued entry
        out_rdy = 1'b0;
        accept_op(mk(3'd0, 5'd9, 1'b0), 64'd5, 64'd0);
        accept_op(mk(3'd0, 5'd10, 1'b0), 64'd7, 64'd3);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check("rs_in_rdy", {63'd0, c_rdy}, 64'd0);
        @(posedge clk);
        #1;
        check("rs_out_vld", {63'd0, c_vld}, 64'd0);
        check("rs_busy", {63'd0, c_busy}, 64'd0);
        check("rs_out_data", c_data, 64'd0);
        check("rs_out_rd", {59'd0, c_rd}, 64'd0);
        @(negedge clk) rst = 1'b1;
        #1 check("rs_rdy_after", {63'd0, c_rdy}, 64'd1);
        out_rdy = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1 if (c_vld) seen++;
        end
        check("rs_no_result", 64'(seen), 64'd0);

        // unit still operates normally afterwards
        v0 = vt[0];
        run_vec(v0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle RISC-V M-extension execution unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus the RV64 W-forms when XLEN=64. It accepts one operation at a time from the schedule stage over a valid/ready handshake. It iterates a shift-add multiplier (MUL_STEP bits per cycle) or a restoring divider (1 bit per cycle), and parks finished results in a small result queue. The mprf write port drains that queue over a second valid/ready handshake. A flush input aborts in-flight work.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- MUL_STEP, 2: multiplier bits retired per cycle; legal values 1, 2, 4; must divide 32.
- RQ_DEPTH, 2: result queue entries; legal range 1..4.
- clk  in  1  clock. All state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_vld  in  1  schedule presents an operation.
- in_rdy  out  1  unit accepts; transfer when in_vld & in_rdy.
- instr  in  32  instruction word; rd=[11:7], funct3=[14:12].
- rs0_word, rs1_word  in  XLEN  source operands.
- flush  in  1  abort in-flight operation and empty result queue.
- out_vld  out  1  head of result queue valid.
- out_rdy  in  1  mprf takes head entry; dequeue when out_vld & out_rdy.
- out_rd  out  5  destination register of head entry.
- out_data  out  XLEN  result of head entry.
- busy  out  1  FSM not IDLE, or queue non-empty.

## Operation
- Decode: an op is M-type when instr[1:0]=11, instr[25]=1, and instr[6:2] is one of:
  - 01100 (full width);
  - 01110 (W-form), legal only when XLEN=64.
  - Any other accepted instr is treated as a no-op; nothing is enqueued.
- W-form handling:
  - Operands are the low 32 bits, sign- or zero-extended per funct3.
  - Iteration width is 32.
  - The result is bits [31:0] sign-extended to XLEN.
- Operand width W is XLEN, or 32 for W-forms.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - On accept, if the op is a direct case, compute the result and enqueue it at the same edge; stay IDLE.
  - Otherwise latch the magnitudes, signs, rd and funct3, then go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Direct cases:
  - Multiply with either operand 0 gives 0.
  - Divide by 0: quotient is all-ones; remainder is the dividend.
  - Signed overflow (dividend = most-negative W-bit value, divisor = -1): quotient is the dividend; remainder is 0.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs0 signed, rs1 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
  - Negative operands are converted to magnitudes on accept.
- MUL state:
  - Each cycle adds (multiplicand x next MUL_STEP multiplier bits), shifted into place, into a 2W-bit accumulator.
  - Exactly W/MUL_STEP cycles, then FIX.
- DIV state:
  - Restoring: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - Exactly W cycles, then FIX.
- FIX state:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the result half per funct3: MUL takes the low W bits; MULH* take the high W bits.
  - Enqueue the result; go to IDLE.
- in_rdy = rst & (state==IDLE) & (queue count < RQ_DEPTH).
  - A full queue therefore blocks accept, so FIX can never overflow the queue.
- Result queue:
  - Circular FIFO with RQ_DEPTH entries and wrapping read/write pointers.
  - Simultaneous enqueue and dequeue is legal at any fill level, including full (the dequeue frees the slot in the same cycle) and empty+1.
  - No enqueue-to-output bypass.
- flush:
  - Forces state to IDLE, clears queue count and pointers, and suppresses any enqueue and any accept in that cycle.
  - in_rdy is 0 during flush.
- Reset (rst=0 at an edge):
  - state=IDLE, queue empty, all datapath registers 0.
  - Outputs: out_vld=0, out_rd=0, out_data=0, busy=0, in_rdy=0 while rst=0.
  - Applies mid-operation identically to flush.

## Timing
- Accept at edge E0.
- Direct case: entry is visible on out_vld from cycle E0+1.
- MUL: cycles 1..W/MUL_STEP iterate; FIX is in cycle W/MUL_STEP+1; out_vld is high from cycle W/MUL_STEP+2.
  - Example: XLEN=32, MUL_STEP=2 gives 16 iterations, out_vld at cycle 18.
- DIV: FIX is in cycle W+1; out_vld is high from cycle W+2 (34 for W=32).
- in_rdy is back to 1 in the cycle after FIX, or after the direct accept, if the queue has space.
  - Back-to-back direct ops are accepted every cycle until the queue is full.
- out_data/out_rd are stable while out_vld=1 and out_rdy=0.
- Dequeue takes effect at the edge; the next entry is presented in the following cycle.

## Test plan
- MUL 7 x -3 (XLEN=32, MUL_STEP=2) -> out_data=0xFFFFFFEB, out_vld at cycle 18. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2; each gives out_vld at cycle 34.
- Direct cases: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0; MUL x*0 -> 0; each out_vld at cycle 1.
- Backpressure: out_rdy=0, RQ_DEPTH=2, three direct ops offered back-to-back -> two accepted, in_rdy=0 on third. Raise out_rdy -> entries drain in order, third accepted after first dequeue.
- Flush in DIV cycle 10 with one queued entry -> no result ever emitted, out_vld=0 next cycle, busy=0, in_rdy=1 the cycle after flush deasserts. Repeat with rst=0 mid-MUL -> same.
- XLEN=64: MULW 0x7FFFFFFF x 2 -> 0xFFFFFFFFFFFFFFFE; DIVW 0x1_0000000A / 5 -> 2 (upper bits ignored); out_vld at cycle 18 and 34 respectively.
